write_back: RTL and testbench

- Final stage of the multicycle 16-bit CPU, directly downstream of the memory-access stage.
- Consumes that stage's DATA_OUT, OPCD_OUT, ADDR_REG_OUT and OPT_BIT_OUT, and commits results to the 32x16 general register bank it owns.
- Serves two combinational read ports to decode, counts retired instructions, and latches HALT.

---
 rtl/write_back.sv | 168 ++++++++++++++++
 tb/tb_write_back.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// write_back: final stage of the multicycle 16-bit CPU.
// Latches one retiring result from the memory-access stage, commits it to
// the 32x16 general register bank, pulses DONE, counts retired instructions
// and parks in HALT on the halt opcode. Decode reads the bank through two
// combinational ports with a bypass of the value being committed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for VALID_IN; captures the incoming result fields
// LATCH | fields held; gives the bank read a full cycle before the merge
// WRITE | merged value presented; register updated at the end of cycle
// DONE  | one-cycle retire pulse; counter bumps at the end of cycle
// HALT  | halt opcode retired; only RST leaves this state
module write_back #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int ALU_OP_MAX = 15,
    parameter int OP_LOAD    = 16,
    parameter int OP_HALT    = 31
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VALID_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [4:0]        OPCD_IN,
    input  logic [ADDR_W-1:0] ADDR_REG_IN,
    input  logic              OPT_BIT_IN,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [DATA_W-1:0] RD_DATA_A,
    output logic [DATA_W-1:0] RD_DATA_B,
    output logic              REG_WRITE_EN,
    output logic [ADDR_W-1:0] REG_WRITE_ADDR,
    output logic [DATA_W-1:0] REG_WRITE_DATA,
    output logic              DONE,
    output logic              HALTED,
    output logic [15:0]       RETIRED_CNT,
    output logic [2:0]        ESTADO
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [4:0] ALU_MAX_C = 5'(ALU_OP_MAX);
    localparam logic [4:0] LOAD_C    = 5'(OP_LOAD);
    localparam logic [4:0] HALT_C    = 5'(OP_HALT);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        opcd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              opt_q;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREG];

    logic              wr_cond;
    logic              wr_en;
    logic [DATA_W-1:0] merged;

    // Commit qualifier and byte/word merge against the current register value.
    always_comb begin
        wr_cond = ((opcd_q >= 5'd1) && (opcd_q <= ALU_MAX_C) || (opcd_q == LOAD_C))
                  && (addr_q != '0);
        if (opt_q) begin
            merged = {regs_q[addr_q][DATA_W-1:8], data_q[7:0]};
        end else begin
            merged = data_q;
        end
        wr_en = (state_q == S_WRITE) && wr_cond;
    end

    // State register; reset wins over every transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; unused codes fall back to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = VALID_IN ? S_LATCH : S_IDLE;
            S_LATCH: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = (opcd_q == HALT_C) ? S_HALT : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs of the sequencer.
    always_comb begin
        DONE         = (state_q == S_DONE);
        HALTED       = (state_q == S_HALT);
        REG_WRITE_EN = wr_en;
        ESTADO       = state_q;
    end

    // Capture the retiring instruction only when accepted in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= '0;
            opcd_q <= '0;
            addr_q <= '0;
            opt_q  <= 1'b0;
        end else if ((state_q == S_IDLE) && VALID_IN) begin
            data_q <= DATA_IN;
            opcd_q <= OPCD_IN;
            addr_q <= ADDR_REG_IN;
            opt_q  <= OPT_BIT_IN;
        end
    end

    // Register bank; r0 is never written because wr_cond excludes address 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[addr_q] <= merged;
        end
    end

    // Retired counter saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_DONE && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Retired counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read ports with bypass of the value committing this cycle.
    always_comb begin
        if (wr_en && (RD_ADDR_A == addr_q)) begin
            RD_DATA_A = merged;
        end else begin
            RD_DATA_A = regs_q[RD_ADDR_A];
        end
        if (wr_en && (RD_ADDR_B == addr_q)) begin
            RD_DATA_B = merged;
        end else begin
            RD_DATA_B = regs_q[RD_ADDR_B];
        end
    end

    assign REG_WRITE_ADDR = addr_q;
    assign REG_WRITE_DATA = merged;
    assign RETIRED_CNT    = cnt_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: table vectors, hand sequences for
// busy/reset/halt corners, then random instructions against a register-array model.
module tb_write_back;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VALID_IN;
    logic [15:0] DATA_IN;
    logic [4:0]  OPCD_IN;
    logic [4:0]  ADDR_REG_IN;
    logic        OPT_BIT_IN;
    logic [4:0]  RD_ADDR_A;
    logic [4:0]  RD_ADDR_B;
    logic [15:0] RD_DATA_A;
    logic [15:0] RD_DATA_B;
    logic        REG_WRITE_EN;
    logic [4:0]  REG_WRITE_ADDR;
    logic [15:0] REG_WRITE_DATA;
    logic        DONE;
    logic        HALTED;
    logic [15:0] RETIRED_CNT;
    logic [2:0]  ESTADO;

    write_back dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .DATA_IN(DATA_IN),
        .OPCD_IN(OPCD_IN), .ADDR_REG_IN(ADDR_REG_IN), .OPT_BIT_IN(OPT_BIT_IN),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
        .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B),
        .REG_WRITE_EN(REG_WRITE_EN), .REG_WRITE_ADDR(REG_WRITE_ADDR),
        .REG_WRITE_DATA(REG_WRITE_DATA), .DONE(DONE), .HALTED(HALTED),
        .RETIRED_CNT(RETIRED_CNT), .ESTADO(ESTADO)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [32];
    logic [15:0] cnt_model;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  op;
        logic [4:0]  addr;
        logic        opt;
        logic        exp_we;
        logic [15:0] exp_val;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        VALID_IN = 1'b0;
        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 16'h0;
        cnt_model = 16'h0;
    endtask

    function automatic bit writes(input logic [4:0] op, input logic [4:0] a);
        return ((op >= 5'd1 && op <= 5'd15) || op == 5'd16) && (a != 5'd0);
    endfunction

    // Runs one instruction from IDLE through retirement, checking every phase.
    task automatic issue(input logic [15:0] d, input logic [4:0] op, input logic [4:0] a,
                         input logic opt, input logic exp_we, input logic [15:0] exp_val,
                         input bit hold);
        logic [15:0] mrg;
        logic [4:0]  rb;
        mrg = opt ? {model[a][15:8], d[7:0]} : d;
        rb  = 5'($urandom);
        chk("idle_state", ESTADO, 3'd0);
        VALID_IN = 1'b1; DATA_IN = d; OPCD_IN = op; ADDR_REG_IN = a; OPT_BIT_IN = opt;
        RD_ADDR_A = a; RD_ADDR_B = rb;
        step();
        chk("latch_state", ESTADO, 3'd1);
        chk("latch_we", REG_WRITE_EN, 1'b0);
        chk("latch_done", DONE, 1'b0);
        if (hold) begin
            DATA_IN = ~d; OPCD_IN = op ^ 5'h1; ADDR_REG_IN = a ^ 5'h1; OPT_BIT_IN = ~opt;
        end else begin
            VALID_IN = 1'b0;
        end
        step();
        chk("write_state", ESTADO, 3'd2);
        chk("write_en", REG_WRITE_EN, exp_we);
        chk("write_addr", REG_WRITE_ADDR, a);
        chk("write_data", REG_WRITE_DATA, mrg);
        chk("bypass_a", RD_DATA_A, exp_we ? exp_val : model[a]);
        chk("bypass_b", RD_DATA_B, (exp_we && rb == a) ? exp_val : model[rb]);
        chk("write_done", DONE, 1'b0);
        step();
        if (exp_we) model[a] = exp_val;
        chk("done_state", ESTADO, 3'd3);
        chk("done_pulse", DONE, 1'b1);
        chk("done_we", REG_WRITE_EN, 1'b0);
        chk("reg_value", RD_DATA_A, exp_val);
        chk("cnt_before", RETIRED_CNT, cnt_model);
        step();
        if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        chk("after_state", ESTADO, (op == 5'd31) ? 3'd4 : 3'd0);
        chk("after_done", DONE, 1'b0);
        chk("cnt_after", RETIRED_CNT, cnt_model);
    endtask

    initial begin
        logic [4:0]  op, a;
        logic [15:0] d, mrg, ev;
        logic        opt, we;
        int          r;

        VALID_IN = 0; DATA_IN = 0; OPCD_IN = 0; ADDR_REG_IN = 0; OPT_BIT_IN = 0;
        RD_ADDR_A = 0; RD_ADDR_B = 0; RST = 1;

        vecs[0] = '{16'h1234, 5'd3,  5'd5,  1'b0, 1'b1, 16'h1234};
        vecs[1] = '{16'hABCD, 5'd16, 5'd5,  1'b1, 1'b1, 16'h12CD};
        vecs[2] = '{16'h5555, 5'd3,  5'd0,  1'b0, 1'b0, 16'h0000};
        vecs[3] = '{16'h7777, 5'd17, 5'd7,  1'b0, 1'b0, 16'h0000};
        vecs[4] = '{16'hBEEF, 5'd15, 5'd31, 1'b0, 1'b1, 16'hBEEF};
        vecs[5] = '{16'h00A5, 5'd0,  5'd6,  1'b0, 1'b0, 16'h0000};
        vecs[6] = '{16'h1111, 5'd1,  5'd1,  1'b1, 1'b1, 16'h0011};
        vecs[7] = '{16'h2222, 5'd18, 5'd2,  1'b0, 1'b0, 16'h0000};

        do_reset();
        chk("rst_state", ESTADO, 3'd0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_halted", HALTED, 1'b0);
        chk("rst_we", REG_WRITE_EN, 1'b0);
        chk("rst_cnt", RETIRED_CNT, 16'd0);
        chk("rst_waddr", REG_WRITE_ADDR, 5'd0);
        chk("rst_wdata", REG_WRITE_DATA, 16'd0);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].data, vecs[i].op, vecs[i].addr, vecs[i].opt,
                  vecs[i].exp_we, vecs[i].exp_val, 1'b0);
        end
        RD_ADDR_A = 5'd0;
        #1;
        chk("r0_zero", RD_DATA_A, 16'h0);
        chk("table_cnt", RETIRED_CNT, 16'd8);

        // VALID held high through three back-to-back instructions.
        do_reset();
        issue(16'hA001, 5'd2,  5'd10, 1'b0, 1'b1, 16'hA001, 1'b1);
        issue(16'hB002, 5'd4,  5'd11, 1'b0, 1'b1, 16'hB002, 1'b1);
        issue(16'hC0C3, 5'd16, 5'd10, 1'b1, 1'b1, 16'hA0C3, 1'b1);
        VALID_IN = 1'b0;
        chk("busy_cnt", RETIRED_CNT, 16'd3);

        // Reset asserted during WRITE discards the commit.
        do_reset();
        VALID_IN = 1'b1; DATA_IN = 16'hFFFF; OPCD_IN = 5'd3; ADDR_REG_IN = 5'd9;
        OPT_BIT_IN = 1'b0; RD_ADDR_A = 5'd9;
        step();
        VALID_IN = 1'b0;
        step();
        chk("mid_write_state", ESTADO, 3'd2);
        chk("mid_write_en", REG_WRITE_EN, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_state", ESTADO, 3'd0);
        chk("mid_rst_r9", RD_DATA_A, 16'h0);
        chk("mid_rst_done", DONE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_nodone", DONE, 1'b0);
        end
        chk("mid_rst_cnt", RETIRED_CNT, 16'd0);

        // Halt: retire, park, ignore VALID, leave on reset.
        do_reset();
        issue(16'h4444, 5'd5, 5'd3, 1'b0, 1'b1, 16'h4444, 1'b0);
        issue(16'h9999, 5'd31, 5'd3, 1'b0, 1'b0, 16'h4444, 1'b0);
        chk("halted", HALTED, 1'b1);
        VALID_IN = 1'b1; DATA_IN = 16'h5A5A; OPCD_IN = 5'd3; ADDR_REG_IN = 5'd3;
        RD_ADDR_A = 5'd3;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("halt_stay", ESTADO, 3'd4);
            chk("halt_nowe", REG_WRITE_EN, 1'b0);
        end
        chk("halt_reg", RD_DATA_A, 16'h4444);
        chk("halt_cnt", RETIRED_CNT, 16'd2);
        VALID_IN = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("halt_exit_state", ESTADO, 3'd0);
        chk("halt_exit_halted", HALTED, 1'b0);

        // Random instructions against the register-array model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      op = 5'($urandom_range(1, 15));
            else if (r < 8) op = 5'd16;
            else if (r < 9) op = 5'($urandom_range(17, 30));
            else            op = 5'd0;
            a   = 5'($urandom_range(0, 31));
            d   = 16'($urandom);
            opt = 1'($urandom);
            we  = writes(op, a);
            mrg = opt ? {model[a][15:8], d[7:0]} : d;
            ev  = we ? mrg : model[a];
            issue(d, op, a, opt, we, ev, 1'($urandom));
        end
        VALID_IN = 1'b0;
        for (int i = 0; i < 32; i++) begin
            RD_ADDR_B = 5'(i);
            #1;
            chk("final_regs", RD_DATA_B, model[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
